// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: ALU results win by default, load results wait in a FIFO,
// and a starvation counter forces a DRAIN phase that stalls the ALU until the queue is empty.
module reg_writeback #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [3:0]  alu_dsel,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [3:0]  ld_dsel,
  input  logic [31:0] ld_data,
  output logic        WE,
  output logic [3:0]  Dsel,
  output logic [31:0] DIN,
  output logic [15:0] pend_mask
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 8;

  typedef enum logic {NORMAL = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   starve_q, starve_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [SW-1:0]   ent_dsel_q [DEPTH];
  logic [SW-1:0]   ent_dsel_d [DEPTH];
  logic [DW-1:0]   ent_data_q [DEPTH];
  logic [DW-1:0]   ent_data_d [DEPTH];
  logic            we_q, we_d;
  logic [SW-1:0]   dsel_q, dsel_d;
  logic [DW-1:0]   din_q, din_d;
  logic            stall_q, stall_d;
  logic            push, pop;

  // Acceptance depends only on registered state; a same-cycle pop gives no credit.
  assign ld_ready  = (state_q == NORMAL) && (count_q < CW'(DEPTH));
  assign alu_stall = stall_q;
  assign WE        = we_q;
  assign Dsel      = dsel_q;
  assign DIN       = din_q;

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend_mask[ent_dsel_q[i]] = 1'b1;
    end
  end

  // Selection, queue update and starvation/state control.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    vld_d      = vld_q;
    ent_dsel_d = ent_dsel_q;
    ent_data_d = ent_data_q;
    we_d       = 1'b0;
    dsel_d     = dsel_q;
    din_d      = din_q;
    pop        = 1'b0;
    push       = ld_valid && ld_ready;

    case (state_q)
      NORMAL: begin
        if (alu_valid) begin
          we_d   = 1'b1;
          dsel_d = alu_dsel;
          din_d  = alu_data;
          if (count_q != '0) begin
            starve_d = starve_q + TW'(1);
            if (starve_d == TW'(STARVE_LIM)) begin
              state_d  = DRAIN;
              starve_d = '0;
            end
          end else begin
            starve_d = '0;
          end
        end else begin
          starve_d = '0;
          pop      = (count_q != '0);
        end
      end
      DRAIN: begin
        pop = (count_q != '0);
        if (count_q <= CW'(1)) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase

    if (pop) begin
      we_d          = 1'b1;
      dsel_d        = ent_dsel_q[head_q];
      din_d         = ent_data_q[head_q];
      vld_d[head_q] = 1'b0;
      head_d        = head_q + AW'(1);
    end
    if (push) begin
      ent_dsel_d[tail_q] = ld_dsel;
      ent_data_d[tail_q] = ld_data;
      vld_d[tail_q]      = 1'b1;
      tail_d             = tail_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    stall_d = (state_d == DRAIN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= NORMAL;
      starve_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      vld_q    <= '0;
      we_q     <= 1'b0;
      dsel_q   <= '0;
      din_q    <= '0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      vld_q    <= vld_d;
      we_q     <= we_d;
      dsel_q   <= dsel_d;
      din_q    <= din_d;
      stall_q  <= stall_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by vld_q.
  always_ff @(posedge clock) begin
    ent_dsel_q <= ent_dsel_d;
    ent_data_q <= ent_data_d;
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: each task drives one scenario and checks
// outputs one time unit after the rising edge against hand-computed values.
module tb_reg_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [3:0]  alu_dsel;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_dsel;
  logic [31:0] ld_data;
  logic        WE;
  logic [3:0]  Dsel;
  logic [31:0] DIN;
  logic [15:0] pend_mask;

  int tests_run    = 0;
  int tests_failed = 0;

  reg_writeback #(.DEPTH(4), .STARVE_LIM(8)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_dsel(alu_dsel), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dsel(ld_dsel), .ld_data(ld_data),
    .WE(WE), .Dsel(Dsel), .DIN(DIN), .pend_mask(pend_mask)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0;
    alu_dsel = '0; alu_data = '0; ld_dsel = '0; ld_data = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (WE !== 1'b0) begin tests_failed++; $display("FAIL rst_we got %0b want 0", WE); end
    tests_run++; if (Dsel !== 4'd0) begin tests_failed++; $display("FAIL rst_dsel got %0d want 0", Dsel); end
    tests_run++; if (DIN !== 32'd0) begin tests_failed++; $display("FAIL rst_din got %h want 0", DIN); end
    tests_run++; if (alu_stall !== 1'b0) begin tests_failed++; $display("FAIL rst_stall got %0b want 0", alu_stall); end
    tests_run++; if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready got %0b want 1", ld_ready); end
    tests_run++; if (pend_mask !== 16'h0) begin tests_failed++; $display("FAIL rst_pend got %h want 0", pend_mask); end
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_dsel = 4'd3; alu_data = 32'h0000_00AA;
    tick();
    tests_run++; if (WE !== 1'b1) begin tests_failed++; $display("FAIL alu_we got %0b want 1", WE); end
    tests_run++; if (Dsel !== 4'd3) begin tests_failed++; $display("FAIL alu_dsel got %0d want 3", Dsel); end
    tests_run++; if (DIN !== 32'hAA) begin tests_failed++; $display("FAIL alu_din got %h want aa", DIN); end
    alu_valid = 1'b0;
    tick();
    tests_run++; if (WE !== 1'b0) begin tests_failed++; $display("FAIL alu_idle_we got %0b want 0", WE); end
    tests_run++; if (Dsel !== 4'd3 || DIN !== 32'hAA) begin
      tests_failed++; $display("FAIL alu_hold got %0d/%h want 3/aa", Dsel, DIN); end
  endtask

  task automatic test_fill();
    do_reset();
    alu_valid = 1'b1; alu_dsel = 4'd1; alu_data = 32'h1;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_dsel = 4'(8 + i); ld_data = 32'(i);
      tests_run++; if (ld_ready !== (i < 4)) begin
        tests_failed++; $display("FAIL fill_ready[%0d] got %0b want %0b", i, ld_ready, (i < 4)); end
      tick();
    end
    ld_valid = 1'b0;
    tests_run++; if (pend_mask !== 16'h0F00) begin tests_failed++; $display("FAIL fill_pend got %h want 0f00", pend_mask); end
    tests_run++; if (ld_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_full got %0b want 0", ld_ready); end
    tests_run++; if (alu_stall !== 1'b0) begin tests_failed++; $display("FAIL fill_stall got %0b want 0", alu_stall); end
  endtask

  task automatic test_starve();
    do_reset();
    alu_valid = 1'b1; alu_dsel = 4'd2; alu_data = 32'h100;
    ld_valid = 1'b1; ld_dsel = 4'd6; ld_data = 32'h61;
    tick();
    ld_dsel = 4'd7; ld_data = 32'h72;
    tick();
    ld_valid = 1'b0;
    // One starved cycle already counted; seven more reach the limit.
    for (int k = 0; k < 7; k++) begin
      tick();
      tests_run++; if (alu_stall !== (k == 6)) begin
        tests_failed++; $display("FAIL starve_stall[%0d] got %0b want %0b", k, alu_stall, (k == 6)); end
    end
    tests_run++; if (ld_ready !== 1'b0) begin tests_failed++; $display("FAIL drain_ready got %0b want 0", ld_ready); end
    tick();
    tests_run++; if (WE !== 1'b1 || Dsel !== 4'd6 || DIN !== 32'h61 || alu_stall !== 1'b1) begin
      tests_failed++; $display("FAIL drain_pop0 got %0b/%0d/%h/%0b want 1/6/61/1", WE, Dsel, DIN, alu_stall); end
    tick();
    tests_run++; if (WE !== 1'b1 || Dsel !== 4'd7 || DIN !== 32'h72 || alu_stall !== 1'b0) begin
      tests_failed++; $display("FAIL drain_pop1 got %0b/%0d/%h/%0b want 1/7/72/0", WE, Dsel, DIN, alu_stall); end
    tests_run++; if (pend_mask !== 16'h0 || ld_ready !== 1'b1) begin
      tests_failed++; $display("FAIL drain_done got %h/%0b want 0/1", pend_mask, ld_ready); end
    alu_valid = 1'b0;
    tick();
    tests_run++; if (WE !== 1'b0) begin tests_failed++; $display("FAIL drain_idle got %0b want 0", WE); end
  endtask

  task automatic test_same_dest();
    do_reset();
    ld_valid = 1'b1; ld_dsel = 4'd5; ld_data = 32'h11;
    tick();
    tests_run++; if (WE !== 1'b0 || pend_mask !== 16'h0020) begin
      tests_failed++; $display("FAIL dup_push got %0b/%h want 0/0020", WE, pend_mask); end
    ld_data = 32'h22;
    tick();
    ld_valid = 1'b0;
    tests_run++; if (WE !== 1'b1 || Dsel !== 4'd5 || DIN !== 32'h11 || pend_mask !== 16'h0020) begin
      tests_failed++; $display("FAIL dup_first got %0b/%0d/%h/%h want 1/5/11/0020", WE, Dsel, DIN, pend_mask); end
    tick();
    tests_run++; if (WE !== 1'b1 || Dsel !== 4'd5 || DIN !== 32'h22 || pend_mask !== 16'h0) begin
      tests_failed++; $display("FAIL dup_second got %0b/%0d/%h/%h want 1/5/22/0", WE, Dsel, DIN, pend_mask); end
    tick();
    tests_run++; if (WE !== 1'b0 || DIN !== 32'h22) begin
      tests_failed++; $display("FAIL dup_final got %0b/%h want 0/22", WE, DIN); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    alu_valid = 1'b1; alu_dsel = 4'd1; alu_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_dsel = 4'(10 + i); ld_data = 32'(i + 1);
      tick();
    end
    ld_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    tests_run++; if (alu_stall !== 1'b1) begin tests_failed++; $display("FAIL mid_stall got %0b want 1", alu_stall); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; alu_valid = 1'b0;
    tests_run++; if (WE !== 1'b0 || pend_mask !== 16'h0 || alu_stall !== 1'b0 || ld_ready !== 1'b1) begin
      tests_failed++; $display("FAIL mid_reset got %0b/%h/%0b/%0b want 0/0/0/1", WE, pend_mask, alu_stall, ld_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++; if (WE !== 1'b0) begin tests_failed++; $display("FAIL mid_stale[%0d] got %0b want 0", k, WE); end
    end
  endtask

  task automatic test_alternating();
    do_reset();
    alu_dsel = 4'd4; alu_data = 32'h44;
    for (int k = 0; k < 10; k++) begin
      alu_valid = (k % 2 == 0);
      ld_valid = (k == 0); ld_dsel = 4'd9; ld_data = 32'h99;
      tick();
      tests_run++;
      if (WE !== ((k % 2 == 0) || k == 1) || Dsel !== ((k == 1) ? 4'd9 : 4'd4) || alu_stall !== 1'b0) begin
        tests_failed++; $display("FAIL alt[%0d] got %0b/%0d/%0b want %0b/%0d/0", k, WE, Dsel, alu_stall,
                                 ((k % 2 == 0) || k == 1), ((k == 1) ? 4'd9 : 4'd4)); end
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_fill();
    test_starve();
    test_same_dest();
    test_reset_mid_drain();
    test_alternating();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
